// File: rtl/dap_swj_sequence_pkg.sv
// Shared DAP command constants and the SWJ sequence worker state encoding.
package dap_swj_sequence_pkg;

  localparam logic [7:0] DAP_SWJ_SEQUENCE = 8'h12;
  localparam logic [7:0] DAP_OK           = 8'h00;
  localparam logic [7:0] DAP_ERROR        = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_RD,
    ST_LEN_WAIT,
    ST_DAT_RD,
    ST_DAT_WAIT,
    ST_LOW,
    ST_HIGH,
    ST_RESP0,
    ST_RESP1,
    ST_CAPT,
    ST_DONE
  } swj_state_e;

  // A bit-count byte of zero encodes a full 256-bit sequence.
  function automatic logic [8:0] bit_count(input logic [7:0] count_byte);
    return (count_byte == 8'd0) ? 9'd256 : {1'b0, count_byte};
  endfunction

endpackage

// File: rtl/dap_swj_sequence_swj_clk_gen.sv
// SWCLK phase timer: counts clk_div+1 cycles per phase while a phase runs.
module swj_clk_gen #(
  parameter int CLK_DIV_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic                     run,
  input  logic                     low,
  output logic                     phase_end,
  output logic                     swclk
);

  logic [CLK_DIV_WIDTH-1:0] div_q;
  logic [CLK_DIV_WIDTH-1:0] cnt_q;

  // Half-period is captured once per sequence, when the request is accepted.
  always_ff @(posedge clk) begin
    if (load) div_q <= clk_div;
  end

  // Phase counter restarts at every phase boundary and idles at zero.
  always_ff @(posedge clk) begin
    if (reset)                  cnt_q <= '0;
    else if (!run || phase_end) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end

  assign phase_end = run && (cnt_q == div_q);
  assign swclk     = !(run && low);

endmodule

// File: rtl/dap_swj_sequence.sv
// DAP_SWJ_Sequence worker: shifts 1..256 bits LSB-first onto SWDIO/TMS.
// Optional build macro SWJ_SEQ_CAPTURE_EN: samples SWDIO_TMS_I at the end of
// each high phase and appends the captured bytes to the response.
module dap_swj_sequence
  import dap_swj_sequence_pkg::*;
#(
  parameter int         CLK_DIV_WIDTH  = 16,
  parameter int         RAM_ADDR_WIDTH = 9,
  parameter logic [7:0] CMD_ID         = DAP_SWJ_SEQUENCE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      done,
  output logic                      busy,
  input  logic [CLK_DIV_WIDTH-1:0]  clk_div,
  output logic [RAM_ADDR_WIDTH-1:0] cmd_ram_addr,
  input  logic [7:0]                cmd_ram_data,
  output logic [RAM_ADDR_WIDTH-1:0] ram_write_addr,
  output logic [7:0]                ram_write_data,
  output logic                      ram_write_en,
  output logic [RAM_ADDR_WIDTH-1:0] packet_len,
  output logic                      SWCLK_TCK_O,
  output logic                      SWDIO_TMS_O,
  output logic                      SWDIO_TMS_T,
  input  logic                      SWDIO_TMS_I
);

  swj_state_e                state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [RAM_ADDR_WIDTH-1:0] pkt_len_q;
  logic [8:0]                cnt_q;
  logic [2:0]                bidx_q;
  logic [6:0]                shift_q;
  logic                      dout_q;
  logic                      phase_end;
  logic                      swclk;
  logic                      accept;

  assign accept = (state_q == ST_IDLE) && start;

  swj_clk_gen #(
    .CLK_DIV_WIDTH(CLK_DIV_WIDTH)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .clk_div  (clk_div),
    .run      ((state_q == ST_LOW) || (state_q == ST_HIGH)),
    .low      (state_q == ST_LOW),
    .phase_end(phase_end),
    .swclk    (swclk)
  );

`ifdef SWJ_SEQ_CAPTURE_EN
  logic [255:0] cap_q;
  logic [7:0]   bitpos_q;
  logic [8:0]   nbits_q;
  logic [4:0]   widx_q;
  logic [5:0]   nbytes;

  assign nbytes = 6'(({1'b0, nbits_q} + 10'd7) >> 3);

  // Capture buffer is cleared per request so the last partial byte is zero-padded.
  always_ff @(posedge clk) begin
    if (accept)                              cap_q           <= '0;
    else if ((state_q == ST_HIGH) && phase_end) cap_q[bitpos_q] <= SWDIO_TMS_I;
  end

  // Capture bookkeeping: bit position, total bits and response byte index.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitpos_q <= '0;
      nbits_q  <= '0;
      widx_q   <= '0;
    end else begin
      if (accept)                                 bitpos_q <= '0;
      else if ((state_q == ST_HIGH) && phase_end) bitpos_q <= bitpos_q + 8'd1;
      if (state_q == ST_LEN_WAIT) nbits_q <= bit_count(cmd_ram_data);
      if (state_q == ST_RESP1)     widx_q <= '0;
      else if (state_q == ST_CAPT) widx_q <= widx_q + 5'd1;
    end
  end
`else
  logic unused_swdio_i;
  assign unused_swdio_i = SWDIO_TMS_I;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_LEN_RD;
      ST_LEN_RD:   state_d = ST_LEN_WAIT;
      ST_LEN_WAIT: state_d = ST_DAT_RD;
      ST_DAT_RD:   state_d = ST_DAT_WAIT;
      ST_DAT_WAIT: state_d = ST_LOW;
      ST_LOW:      if (phase_end) state_d = ST_HIGH;
      ST_HIGH: begin
        if (phase_end) begin
          if (cnt_q == 9'd1)       state_d = ST_RESP0;
          else if (bidx_q == 3'd7) state_d = ST_DAT_RD;
          else                     state_d = ST_LOW;
        end
      end
      ST_RESP0:    state_d = ST_RESP1;
`ifdef SWJ_SEQ_CAPTURE_EN
      ST_RESP1:    state_d = ST_CAPT;
      ST_CAPT:     if ({1'b0, widx_q} == (nbytes - 6'd1)) state_d = ST_DONE;
`else
      ST_RESP1:    state_d = ST_DONE;
`endif
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Sequencing registers: read address, bit counters, pin data and response length.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      bidx_q    <= '0;
      dout_q    <= 1'b1;
      pkt_len_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE:     if (start) addr_q <= RAM_ADDR_WIDTH'(1);
        ST_LEN_WAIT: begin
          cnt_q  <= bit_count(cmd_ram_data);
          addr_q <= addr_q + 1'b1;
        end
        ST_DAT_WAIT: begin
          addr_q <= addr_q + 1'b1;
          bidx_q <= 3'd0;
          dout_q <= cmd_ram_data[0];
        end
        ST_HIGH: begin
          if (phase_end) begin
            cnt_q  <= cnt_q - 9'd1;
            bidx_q <= bidx_q + 3'd1;
            if (state_d == ST_LOW) dout_q <= shift_q[0];
          end
        end
`ifdef SWJ_SEQ_CAPTURE_EN
        ST_RESP1:    pkt_len_q <= RAM_ADDR_WIDTH'(2) + RAM_ADDR_WIDTH'(nbytes);
`else
        ST_RESP1:    pkt_len_q <= RAM_ADDR_WIDTH'(2);
`endif
        default:     ;
      endcase
    end
  end

  // Remaining bits of the current byte, consumed at each high-phase end.
  always_ff @(posedge clk) begin
    if (state_q == ST_DAT_WAIT)               shift_q <= cmd_ram_data[7:1];
    else if ((state_q == ST_HIGH) && phase_end) shift_q <= shift_q >> 1;
  end

  // Output decode from the current state.
  always_comb begin
    busy           = 1'b1;
    done           = 1'b0;
    ram_write_en   = 1'b0;
    ram_write_addr = '0;
    ram_write_data = '0;
    case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      ST_RESP0: begin
        ram_write_en   = 1'b1;
        ram_write_addr = RAM_ADDR_WIDTH'(0);
        ram_write_data = CMD_ID;
      end
      ST_RESP1: begin
        ram_write_en   = 1'b1;
        ram_write_addr = RAM_ADDR_WIDTH'(1);
        ram_write_data = DAP_OK;
      end
`ifdef SWJ_SEQ_CAPTURE_EN
      ST_CAPT: begin
        ram_write_en   = 1'b1;
        ram_write_addr = RAM_ADDR_WIDTH'(2) + RAM_ADDR_WIDTH'(widx_q);
        ram_write_data = cap_q[{widx_q, 3'b000} +: 8];
      end
`endif
      default: ;
    endcase
    SWDIO_TMS_T  = !busy;
    SWCLK_TCK_O  = swclk;
    SWDIO_TMS_O  = dout_q;
    cmd_ram_addr = addr_q;
    packet_len   = pkt_len_q;
  end

endmodule

// File: tb/tb_dap_swj_sequence.sv
// Self-checking bench for dap_swj_sequence with a bit and response-write scoreboard.
module tb_dap_swj_sequence;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic        busy;
  logic [15:0] clk_div;
  logic [8:0]  cmd_ram_addr;
  logic [7:0]  cmd_ram_data;
  logic [8:0]  ram_write_addr;
  logic [7:0]  ram_write_data;
  logic        ram_write_en;
  logic [8:0]  packet_len;
  logic        SWCLK_TCK_O;
  logic        SWDIO_TMS_O;
  logic        SWDIO_TMS_T;
  logic        SWDIO_TMS_I;

  dap_swj_sequence dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .done          (done),
    .busy          (busy),
    .clk_div       (clk_div),
    .cmd_ram_addr  (cmd_ram_addr),
    .cmd_ram_data  (cmd_ram_data),
    .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data),
    .ram_write_en  (ram_write_en),
    .packet_len    (packet_len),
    .SWCLK_TCK_O   (SWCLK_TCK_O),
    .SWDIO_TMS_O   (SWDIO_TMS_O),
    .SWDIO_TMS_T   (SWDIO_TMS_T),
    .SWDIO_TMS_I   (SWDIO_TMS_I)
  );

  always #5 clk = ~clk;

  logic [7:0] cmem [0:511];
  always @(posedge clk) cmd_ram_data <= cmem[cmd_ram_addr];

  assign SWDIO_TMS_I = SWDIO_TMS_O;

  int          tests = 0;
  int          fails = 0;
  logic [16:0] wq[$];
  logic        bq[$];
  logic [7:0]  pkt [0:31];
  int          exp_phase;
  int          exp_len;
  bit          mon_en = 1'b0;
  int          bits_seen, low_cnt, high_cnt, done_cnt;
  logic        prev_swclk = 1'b1;

  // One clock cycle: advance to the falling edge and score what the DUT shows.
  task automatic step();
    logic [16:0] e;
    logic        b;
    int          exp_h;
    @(negedge clk);
    if (mon_en) begin
      if (ram_write_en === 1'b1) begin
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL resp_write: got addr=%0d data=%02h, required no write", ram_write_addr, ram_write_data);
        end else begin
          e = wq.pop_front();
          if ({ram_write_addr, ram_write_data} !== e) begin
            fails++;
            $display("FAIL resp_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                     ram_write_addr, ram_write_data, e[16:8], e[7:0]);
          end
        end
      end
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) begin
        tests++;
        if (SWDIO_TMS_T !== 1'b0) begin
          fails++;
          $display("FAIL tristate_busy: got T=%b, required 0", SWDIO_TMS_T);
        end
      end
      if (SWCLK_TCK_O === 1'b1 && prev_swclk === 1'b0) begin
        tests++;
        if (low_cnt !== exp_phase) begin
          fails++;
          $display("FAIL swclk_low_len bit %0d: got %0d cycles, required %0d", bits_seen, low_cnt, exp_phase);
        end
        tests++;
        if (bq.size() == 0) begin
          fails++;
          $display("FAIL swdio_bit: got extra bit %0d, required none", bits_seen);
        end else begin
          b = bq.pop_front();
          if (SWDIO_TMS_O !== b) begin
            fails++;
            $display("FAIL swdio_bit %0d: got %b, required %b", bits_seen, SWDIO_TMS_O, b);
          end
        end
        bits_seen++;
        high_cnt = 1;
      end else if (SWCLK_TCK_O === 1'b0 && prev_swclk === 1'b1) begin
        if (bits_seen > 0) begin
          exp_h = exp_phase + (((bits_seen % 8) == 0) ? 2 : 0);
          tests++;
          if (high_cnt !== exp_h) begin
            fails++;
            $display("FAIL swclk_high_len after bit %0d: got %0d cycles, required %0d", bits_seen, high_cnt, exp_h);
          end
        end
        low_cnt = 1;
      end else if (SWCLK_TCK_O === 1'b1) begin
        high_cnt++;
      end else begin
        low_cnt++;
      end
    end
    prev_swclk = SWCLK_TCK_O;
  endtask

  // Load the command RAM and push the expected bit stream and response writes.
  task automatic prepare(input logic [7:0] count_field, input int nbits, input int div);
    int         nbytes;
    logic [7:0] m;
    cmem[0] = 8'h12;
    cmem[1] = count_field;
    for (int i = 0; i < 32; i++) cmem[2 + i] = pkt[i];
    bq.delete();
    wq.delete();
    for (int i = 0; i < nbits; i++) bq.push_back(pkt[i / 8][i % 8]);
    wq.push_back({9'd0, 8'h12});
    wq.push_back({9'd1, 8'h00});
    exp_len = 2;
`ifdef SWJ_SEQ_CAPTURE_EN
    nbytes = (nbits + 7) / 8;
    for (int k = 0; k < nbytes; k++) begin
      m = pkt[k];
      if (k == nbytes - 1 && (nbits % 8) != 0) m = m & 8'((1 << (nbits % 8)) - 1);
      wq.push_back({9'(2 + k), m});
    end
    exp_len = 2 + nbytes;
`else
    nbytes = 0;
    m = 8'd0;
`endif
    exp_phase = div + 1;
    bits_seen = 0;
    low_cnt   = 0;
    high_cnt  = 0;
    done_cnt  = 0;
    mon_en    = 1'b1;
  endtask

  // Issue one request and run until done (bounded), plus a few trailing cycles.
  task automatic run_seq(input logic [7:0] count_field, input int nbits, input int div,
                         input int budget, output int first_fall, output logic busy_seen);
    int n;
    prepare(count_field, nbits, div);
    step();
    start   = 1'b1;
    clk_div = 16'(div);
    step();
    start     = 1'b0;
    busy_seen = busy;
    first_fall = 1;
    while (SWCLK_TCK_O === 1'b1 && first_fall < 50) begin
      step();
      first_fall++;
    end
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    repeat (4) step();
  endtask

  task automatic clear_pkt();
    for (int i = 0; i < 32; i++) pkt[i] = 8'h00;
  endtask

  task automatic test_reset();
    mon_en  = 1'b0;
    reset   = 1'b1;
    start   = 1'b0;
    clk_div = 16'd0;
    repeat (3) step();
    tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++; if (done !== 1'b0)         begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
    tests++; if (ram_write_en !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b, required 0", ram_write_en); end
    tests++; if (cmd_ram_addr !== 9'd0) begin fails++; $display("FAIL reset_cmd_addr: got %0d, required 0", cmd_ram_addr); end
    tests++; if (ram_write_addr !== 9'd0) begin fails++; $display("FAIL reset_wr_addr: got %0d, required 0", ram_write_addr); end
    tests++; if (packet_len !== 9'd0)   begin fails++; $display("FAIL reset_packet_len: got %0d, required 0", packet_len); end
    tests++; if (SWCLK_TCK_O !== 1'b1)  begin fails++; $display("FAIL reset_swclk: got %b, required 1", SWCLK_TCK_O); end
    tests++; if (SWDIO_TMS_O !== 1'b1)  begin fails++; $display("FAIL reset_swdio: got %b, required 1", SWDIO_TMS_O); end
    tests++; if (SWDIO_TMS_T !== 1'b1)  begin fails++; $display("FAIL reset_t: got %b, required 1", SWDIO_TMS_T); end
    reset = 1'b0;
    repeat (2) step();
  endtask

  // Shared end-of-sequence checks are written out per test below.
  task automatic test_basic();
    int ff; logic bs;
    clear_pkt();
    pkt[0] = 8'hA5;
    run_seq(8'd8, 8, 0, 2000, ff, bs);
    tests++; if (bs !== 1'b1)        begin fails++; $display("FAIL basic_busy: got %b, required 1", bs); end
    tests++; if (ff !== 5)           begin fails++; $display("FAIL basic_first_fall: got %0d, required 5", ff); end
    tests++; if (bits_seen !== 8)    begin fails++; $display("FAIL basic_bits: got %0d, required 8", bits_seen); end
    tests++; if (done_cnt !== 1)     begin fails++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt); end
    tests++; if (wq.size() !== 0)    begin fails++; $display("FAIL basic_writes_left: got %0d, required 0", wq.size()); end
    tests++; if (packet_len !== 9'(exp_len)) begin fails++; $display("FAIL basic_packet_len: got %0d, required %0d", packet_len, exp_len); end
    tests++; if (SWDIO_TMS_T !== 1'b1) begin fails++; $display("FAIL basic_t_after: got %b, required 1", SWDIO_TMS_T); end
  endtask

  task automatic test_len256();
    int ff; logic bs;
    for (int i = 0; i < 32; i++) pkt[i] = 8'hFF;
    run_seq(8'd0, 256, 0, 5000, ff, bs);
    tests++; if (bits_seen !== 256)  begin fails++; $display("FAIL len256_bits: got %0d, required 256", bits_seen); end
    tests++; if (done_cnt !== 1)     begin fails++; $display("FAIL len256_done_count: got %0d, required 1", done_cnt); end
    tests++; if (wq.size() !== 0)    begin fails++; $display("FAIL len256_writes_left: got %0d, required 0", wq.size()); end
    tests++; if (packet_len !== 9'(exp_len)) begin fails++; $display("FAIL len256_packet_len: got %0d, required %0d", packet_len, exp_len); end
  endtask

  task automatic test_div4();
    int ff; logic bs;
    clear_pkt();
    pkt[0] = 8'h06;
    run_seq(8'd3, 3, 4, 2000, ff, bs);
    tests++; if (ff !== 5)           begin fails++; $display("FAIL div4_first_fall: got %0d, required 5", ff); end
    tests++; if (bits_seen !== 3)    begin fails++; $display("FAIL div4_bits: got %0d, required 3", bits_seen); end
    tests++; if (done_cnt !== 1)     begin fails++; $display("FAIL div4_done_count: got %0d, required 1", done_cnt); end
    tests++; if (bq.size() !== 0)    begin fails++; $display("FAIL div4_bits_left: got %0d, required 0", bq.size()); end
    tests++; if (wq.size() !== 0)    begin fails++; $display("FAIL div4_writes_left: got %0d, required 0", wq.size()); end
  endtask

  task automatic test_abort();
    int   falls, n, wr_hits, done_hits, ff;
    logic p, bs;
    clear_pkt();
    pkt[0] = 8'hB6;
    prepare(8'd8, 8, 1);
    mon_en = 1'b0;
    step();
    start   = 1'b1;
    clk_div = 16'd1;
    step();
    start = 1'b0;
    falls = 0;
    n = 0;
    while (falls < 5 && n < 200) begin
      p = SWCLK_TCK_O;
      step();
      if (p === 1'b1 && SWCLK_TCK_O === 1'b0) falls++;
      n++;
    end
    tests++; if (falls !== 5) begin fails++; $display("FAIL abort_reach_bit5: got %0d falls, required 5", falls); end
    reset = 1'b1;
    step();
    tests++; if (SWCLK_TCK_O !== 1'b1) begin fails++; $display("FAIL abort_swclk: got %b, required 1", SWCLK_TCK_O); end
    tests++; if (SWDIO_TMS_T !== 1'b1) begin fails++; $display("FAIL abort_t: got %b, required 1", SWDIO_TMS_T); end
    tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL abort_busy: got %b, required 0", busy); end
    reset = 1'b0;
    wr_hits = 0;
    done_hits = 0;
    repeat (30) begin
      step();
      if (ram_write_en === 1'b1) wr_hits++;
      if (done === 1'b1) done_hits++;
    end
    tests++; if (wr_hits !== 0)   begin fails++; $display("FAIL abort_writes: got %0d, required 0", wr_hits); end
    tests++; if (done_hits !== 0) begin fails++; $display("FAIL abort_done: got %0d, required 0", done_hits); end
    pkt[0] = 8'h3C;
    run_seq(8'd8, 8, 0, 2000, ff, bs);
    tests++; if (done_cnt !== 1)  begin fails++; $display("FAIL recover_done_count: got %0d, required 1", done_cnt); end
    tests++; if (bits_seen !== 8) begin fails++; $display("FAIL recover_bits: got %0d, required 8", bits_seen); end
    tests++; if (wq.size() !== 0) begin fails++; $display("FAIL recover_writes_left: got %0d, required 0", wq.size()); end
  endtask

  task automatic test_back_to_back();
    int cyc, busy_hits;
    clear_pkt();
    pkt[0] = 8'h5A;
    prepare(8'd8, 8, 0);
    step();
    start   = 1'b1;
    clk_div = 16'd0;
    step();
    start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      step();
      cyc++;
      if (cyc == 10) start = 1'b1;
      else if (cyc == 11) start = 1'b0;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    busy_hits = 0;
    repeat (40) begin
      step();
      if (busy === 1'b1) busy_hits++;
    end
    tests++; if (done_cnt !== 1)  begin fails++; $display("FAIL b2b_done_count: got %0d, required 1", done_cnt); end
    tests++; if (busy_hits !== 0) begin fails++; $display("FAIL b2b_restart: got %0d busy cycles, required 0", busy_hits); end
    tests++; if (bits_seen !== 8) begin fails++; $display("FAIL b2b_bits: got %0d, required 8", bits_seen); end
    tests++; if (wq.size() !== 0) begin fails++; $display("FAIL b2b_writes_left: got %0d, required 0", wq.size()); end
  endtask

  task automatic test_ten_bits();
    int ff; logic bs;
    clear_pkt();
    pkt[0] = 8'hFF;
    pkt[1] = 8'h03;
    run_seq(8'd10, 10, 1, 2000, ff, bs);
    tests++; if (bits_seen !== 10) begin fails++; $display("FAIL ten_bits: got %0d, required 10", bits_seen); end
    tests++; if (done_cnt !== 1)   begin fails++; $display("FAIL ten_done_count: got %0d, required 1", done_cnt); end
    tests++; if (wq.size() !== 0)  begin fails++; $display("FAIL ten_writes_left: got %0d, required 0", wq.size()); end
    tests++; if (packet_len !== 9'(exp_len)) begin fails++; $display("FAIL ten_packet_len: got %0d, required %0d", packet_len, exp_len); end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    clk_div = 16'd0;
    for (int i = 0; i < 512; i++) cmem[i] = 8'h00;
    test_reset();
    test_basic();
    test_len256();
    test_div4();
    test_abort();
    test_back_to_back();
    test_ten_bits();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
